accel_mem_arbiter: RTL and testbench

Round-robin arbiter sharing the single user-project memory port (exmem BRAM behind the Wishbone decoder) among the FIR, matrix-multiply and quicksort accelerators. Each accelerator issues single-word read/write requests. The arbiter serialises them onto one memory handshake and returns ack, read data and an optional error flag to the winner. It sits between the three accelerator engines and the memory controller inside user_proj_example.

---
 rtl/accel_arb_pkg.sv | 14 +
 rtl/arb_rr_pick.sv | 25 ++
 rtl/accel_mem_arbiter.sv | 100 ++++++++++
 tb/tb_accel_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/accel_arb_pkg.sv
// accel_arb_pkg: FSM encoding, requester IDs and error constant for accel_mem_arbiter
package accel_arb_pkg;
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t BUS = 2'd1;
    localparam arb_state_t ACK = 2'd2;
    localparam logic [1:0] REQ_FIR = 2'd0;
    localparam logic [1:0] REQ_MM = 2'd1;
    localparam logic [1:0] REQ_QS = 2'd2;
    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;
    function automatic logic [1:0] next_ptr(input logic [1:0] w, input int nreq);
        return (int'(w) == nreq - 1) ? REQ_FIR : w + 2'd1;
    endfunction
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: combinational rotate-priority picker starting the search at rr_ptr
module arb_rr_pick #(
    parameter int NREQ = 3,
    parameter int IW = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   winner,
    output logic            found
);
    logic [IW-1:0] idx;
    always_comb begin
        winner = '0;
        found = 1'b0;
        idx = '0;
        // scan from the far end so the candidate closest to rr_ptr overwrites the rest
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[idx]) begin
                winner = idx;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/accel_mem_arbiter.sv
// accel_mem_arbiter: round-robin sharing of one memory port among the FIR, MM and QS engines.
// Define ACCEL_ARB_WDOG_EN to abort memory cycles stalled for TIMEOUT cycles with req_err.
module accel_mem_arbiter
    import accel_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ-1:0] req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0] req_ack,
    output logic [NREQ-1:0] req_err,
    output logic [DW-1:0]   req_rdata,
    output logic            mem_cyc,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack,
    output logic [1:0]      grant_id,
    output logic            busy
);
    arb_state_t state;
    logic [1:0] gid, rr_ptr, win;
    logic found, timeout, we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q;

    arb_rr_pick #(.NREQ(NREQ), .IW(2)) u_pick (
        .req_valid(req_valid),
        .rr_ptr(rr_ptr),
        .winner(win),
        .found(found)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
            gid <= REQ_FIR;
            rr_ptr <= REQ_FIR;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state <= BUS;
                gid <= win;
                rr_ptr <= next_ptr(win, NREQ);
                we_q <= req_we[win];
                addr_q <= req_addr[int'(win)*AW +: AW];
                wdata_q <= req_wdata[int'(win)*DW +: DW];
            end
        end else if (state == BUS) begin
            if (mem_ack || timeout) begin
                state <= ACK;
                rdata_q <= mem_ack ? mem_rdata : DW'(DEAD_BEEF);
            end
        end else begin
            state <= IDLE;
        end
    end

    assign busy = state != IDLE;
    assign mem_cyc = state == BUS;
    assign mem_we = we_q;
    assign mem_addr = addr_q;
    assign mem_wdata = wdata_q;
    assign req_rdata = rdata_q;
    assign grant_id = gid;
    assign req_ack = (state == ACK) ? NREQ'(1) << gid : '0;

`ifdef ACCEL_ARB_WDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    logic err_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wd_cnt <= '0;
            err_q <= 1'b0;
        end else begin
            wd_cnt <= (state == BUS && !mem_ack && !timeout) ? wd_cnt + 1'b1 : '0;
            if (state == BUS) err_q <= timeout && !mem_ack;
        end
    end
    assign timeout = state == BUS && wd_cnt == CW'(TIMEOUT);
    assign req_err = err_q ? req_ack : '0;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout = 1'b0;
    assign req_err = '0;
`endif
endmodule

// File: tb/tb_accel_mem_arbiter.sv
// tb_accel_mem_arbiter: directed and randomized checks against a transaction-level arbiter model
module tb_accel_mem_arbiter;
    localparam int NREQ = 3;
    localparam int AW = 12;
    localparam int DW = 32;

    logic wb_clk_i = 1'b0;
    logic wb_rst_n;
    logic [NREQ-1:0] req_valid, req_we, req_ack, req_err;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0] req_rdata, mem_wdata, mem_rdata;
    logic mem_cyc, mem_we, mem_ack, busy;
    logic [AW-1:0] mem_addr;
    logic [1:0] grant_id;

    logic [AW-1:0] r_addr [NREQ];
    logic [DW-1:0] r_wdata [NREQ];
    logic [DW-1:0] ram [0:4095];
    logic [DW-1:0] ref_m [0:4095];
    int checks = 0;
    int errors = 0;
    int ptr = 0;
    int cyc = 0;

    for (genvar g = 0; g < NREQ; g++) begin : g_drv
        assign req_addr[g*AW +: AW] = r_addr[g];
        assign req_wdata[g*DW +: DW] = r_wdata[g];
    end

    accel_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(64)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n(wb_rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
        .mem_cyc(mem_cyc), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant_id(grant_id), .busy(busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    // one full arbitration: starts and ends on a negedge with the DUT idle
    task automatic txn(input int lat, input bit keep, output int w, output int ack_cyc);
        logic [DW-1:0] exp_rd;
        logic rd;
        w = pick(req_valid, ptr);
        rd = !req_we[w];
        exp_rd = ref_m[r_addr[w]];
        if (!rd) ref_m[r_addr[w]] = r_wdata[w];
        tick();
        for (int c = 1; c <= lat; c++) begin
            chk("bus_cyc", 64'(mem_cyc), 64'(1));
            chk("bus_gid", 64'(grant_id), 64'(w));
            chk("bus_we", 64'(mem_we), 64'(!rd));
            chk("bus_addr", 64'(mem_addr), 64'(r_addr[w]));
            chk("bus_wdata", 64'(mem_wdata), 64'(r_wdata[w]));
            chk("bus_noack", 64'(req_ack), 64'(0));
            if (c == lat) begin
                mem_ack = 1'b1;
                mem_rdata = ram[mem_addr];
                if (mem_we) ram[mem_addr] = mem_wdata;
            end
            tick();
            mem_ack = 1'b0;
            mem_rdata = $urandom;
        end
        ack_cyc = cyc;
        chk("ack_cyc_drop", 64'(mem_cyc), 64'(0));
        chk("ack_pulse", 64'(req_ack), 64'(1 << w));
        chk("ack_err", 64'(req_err), 64'(0));
        chk("ack_busy", 64'(busy), 64'(1));
        if (rd) chk("ack_rdata", 64'(req_rdata), 64'(exp_rd));
        ptr = (w + 1) % NREQ;
        if (!keep) req_valid[w] = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_ack", 64'(req_ack), 64'(0));
        if (rd) chk("idle_rdata_hold", 64'(req_rdata), 64'(exp_rd));
    endtask

    initial begin
        int w, w2, a0, a1, a2;
        wb_rst_n = 1'b0;
        req_valid = '0;
        req_we = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            r_addr[i] = '0;
            r_wdata[i] = '0;
        end
        for (int i = 0; i < 4096; i++) begin
            ram[i] = $urandom;
            ref_m[i] = ram[i];
        end
        tick();
        tick();
        chk("rst_cyc", 64'(mem_cyc), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_gid", 64'(grant_id), 64'(0));
        chk("rst_ack", 64'(req_ack), 64'(0));
        chk("rst_err", 64'(req_err), 64'(0));
        chk("rst_rdata", 64'(req_rdata), 64'(0));
        chk("rst_memout", 64'({mem_we, mem_addr, mem_wdata}), 64'(0));
        wb_rst_n = 1'b1;
        tick();

        for (int i = 0; i < NREQ; i++) r_addr[i] = AW'(i + 1);
        req_valid = '1;
        txn(1, 1'b1, w, a0);
        chk("sim_order0", 64'(w), 64'(0));
        txn(1, 1'b1, w, a1);
        chk("sim_order1", 64'(w), 64'(1));
        txn(1, 1'b0, w, a2);
        chk("sim_order2", 64'(w), 64'(2));
        chk("sim_gap01", 64'(a1 - a0), 64'(3));
        chk("sim_gap12", 64'(a2 - a1), 64'(3));
        req_valid = '0;

        ram[16] = 32'h50;
        ref_m[16] = 32'h50;
        r_addr[1] = 12'h010;
        req_valid = 3'b010;
        txn(2, 1'b0, w, a0);
        chk("rd_gid", 64'(grant_id), 64'(1));
        chk("rd_data", 64'(req_rdata), 64'(32'h50));

        r_addr[2] = 12'hFFF;
        r_wdata[2] = 32'h1234_5678;
        req_we[2] = 1'b1;
        req_valid = 3'b100;
        txn(3, 1'b0, w, a0);
        chk("wr_ram", 64'(ram[12'hFFF]), 64'(32'h1234_5678));
        req_we = '0;

        r_addr[0] = 12'h005;
        req_valid = 3'b001;
        txn(1, 1'b1, w, a0);
        r_addr[2] = 12'h007;
        req_valid[2] = 1'b1;
        txn(1, 1'b1, w, a0);
        txn(1, 1'b1, w2, a0);
        chk("fair_qs", 64'(w == 2 || w2 == 2), 64'(1));
        req_valid = '0;
        tick();

        r_addr[1] = 12'h009;
        req_valid = 3'b010;
        tick();
        chk("rst_mid_bus", 64'(mem_cyc), 64'(1));
        wb_rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", 64'(mem_cyc), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_ack", 64'(req_ack), 64'(0));
        @(negedge wb_clk_i);
        wb_rst_n = 1'b1;
        ptr = 0;
        req_valid = '1;
        txn(1, 1'b0, w, a0);
        chk("rst_fir_first", 64'(w), 64'(0));
        req_valid = '0;

        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_we[i] = 1'($urandom_range(0, 1));
                    r_addr[i] = AW'($urandom_range(0, 15));
                    r_wdata[i] = $urandom;
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                tick();
                chk("idle_stay", 64'(busy), 64'(0));
            end else begin
                txn(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), w, a0);
            end
        end
        req_valid = '0;
        tick();

`ifdef ACCEL_ARB_WDOG_EN
        begin
            int t;
            req_we = '0;
            r_addr[0] = 12'h003;
            req_valid = 3'b001;
            t = 0;
            tick();
            t++;
            req_valid = '0;
            while (req_ack == '0 && t < 200) begin
                tick();
                t++;
            end
            chk("wd_latency", 64'(t), 64'(66));
            chk("wd_ack", 64'(req_ack), 64'(1));
            chk("wd_err", 64'(req_err), 64'(1));
            chk("wd_rdata", 64'(req_rdata), 64'(32'hDEAD_BEEF));
            tick();
            chk("wd_idle", 64'(busy), 64'(0));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
